// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: drives a 4-digit common-anode 7-seg display from a
// one-hot digit select, with a double-buffered value, dead-time blanking
// and detection of an illegal select.
// Ports:
//   clk, rst    - clock, async active-high reset
//   sel         - one-hot digit select, digit i = sel[i]
//   load_valid  - upstream offers load_data
//   load_data   - 4 hex nibbles, digit i = load_data[4i+3:4i]
//   load_ready  - pending buffer empty
//   an, seg     - active-low anodes and segments {g,f,e,d,c,b,a}, registered
//   frame_tick  - one-cycle pulse when the pending value becomes active
//   sel_err     - sticky flag for a non-one-hot sel
module seg7_scan_driver #(
    parameter int DEADTIME = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sel,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_tick,
    output logic        sel_err
);

    localparam logic [3:0] DT    = 4'(DEADTIME);
    localparam logic [3:0] AN_OFF = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic [3:0]  sel_q;
    logic [3:0]  dead_cnt;
    logic [15:0] act_data;
    logic [15:0] pend_data;
    logic        pend_full;

    logic        onehot;
    logic        chg;
    logic        swap;
    logic        accept;
    logic [15:0] act_nxt;
    logic [3:0]  an_nxt;
    logic [3:0]  dead_nxt;
    logic [3:0]  nib;
    logic [6:0]  seg_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        s = SEG_OFF;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign load_ready = ~pend_full;
    assign onehot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    assign chg    = (sel != sel_q);
    // frame boundary: change onto digit 0
    assign swap   = onehot && chg && (sel == 4'b0001) && pend_full;
    assign accept = load_valid && !pend_full;
    assign act_nxt = swap ? pend_data : act_data;

    always_comb begin
        an_nxt   = an;
        dead_nxt = dead_cnt;
        if (!onehot) begin
            an_nxt   = AN_OFF;
            dead_nxt = 4'd0;
        end else if (chg) begin
            dead_nxt = DT;
            an_nxt   = (DT != 4'd0) ? AN_OFF : ~sel;
        end else if (dead_cnt > 4'd1) begin
            dead_nxt = dead_cnt - 4'd1;
            an_nxt   = AN_OFF;
        end else if (dead_cnt == 4'd1) begin
            dead_nxt = 4'd0;
            an_nxt   = ~sel_q;
        end
    end

    // decode from the next anode/data so seg always matches an
    always_comb begin
        nib = 4'd0;
        unique case (1'b1)
            !an_nxt[0]: nib = act_nxt[3:0];
            !an_nxt[1]: nib = act_nxt[7:4];
            !an_nxt[2]: nib = act_nxt[11:8];
            !an_nxt[3]: nib = act_nxt[15:12];
            default:    nib = 4'd0;
        endcase
        seg_nxt = (an_nxt == AN_OFF) ? SEG_OFF : hex7(nib);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= 4'd0;
            dead_cnt   <= 4'd0;
            act_data   <= 16'd0;
            pend_data  <= 16'd0;
            pend_full  <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            sel_q      <= sel;
            dead_cnt   <= dead_nxt;
            act_data   <= act_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_tick <= swap;
            if (!onehot)
                sel_err <= 1'b1;
            if (accept)
                pend_data <= load_data;
            pend_full <= accept | (pend_full & ~swap);
        end
    end

endmodule
